hdc_sample_feeder: RTL and testbench

- Upstream front-end of the HDC classifier core.
- Accepts one quantisable feature per cycle over a valid/ready stream and maps it to a level hypervector (im_value) and a position hypervector (im_pos).
- Generates the core's per-sample and per-set control strobes: smp_en, smp_clr, set_clr, state and label.
- Replaces the item-memory ROMs with deterministic on-the-fly generation: a thermometer-flipped level seed and a rotating position seed.

---
 rtl/hdc_sample_feeder.sv | 185 ++++++++++++++++++
 tb/tb_hdc_sample_feeder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hdc_sample_feeder.sv
// hdc_sample_feeder
//   Front-end of the HDC classifier core. Takes one feature per cycle over a
//   valid/ready stream, quantises it to a level, and emits the level
//   hypervector (im_value) and the position hypervector (im_pos) together
//   with the per-sample / per-set control strobes the core accumulates on.
//   Item memories are replaced by on-the-fly generation:
//     level HV  = LVL_SEED with its low lvl*STEP bits inverted (thermometer)
//     pos HV(i) = POS_SEED rotated left by i
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   mode              requested mode (0 = train, 1 = predict), latched on feature 0
//   in_valid/in_ready feature stream handshake; in_ready is high only in FEAT
//   feat              unsigned feature value
//   in_label          class label, latched on feature 0
//   in_set_last       sample closes its training set, latched on feature 0
//   state             mode latched for the current sample
//   smp_en            im_value/im_pos valid for accumulation
//   smp_clr           one-cycle end-of-sample strobe
//   set_clr           one-cycle end-of-training-set strobe
//   im_value, im_pos  level / position hypervectors
//   label             latched label
//   busy              sample in progress or end strobes pending
//
// rst_n is expected to be released synchronously to clk by the reset
// infrastructure; assertion is honoured immediately.

module hdc_sample_feeder #(
  parameter int              DIM      = 1024,
  parameter int              FEAT_NUM = 617,
  parameter int              FEAT_W   = 8,
  parameter int              LVL_NUM  = 16,
  parameter int              CLS_DW   = 5,
  parameter logic [DIM-1:0]  LVL_SEED = {(DIM/16){16'h5A5A}},
  parameter logic [DIM-1:0]  POS_SEED = {(DIM/16){16'hC3A5}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_W-1:0] feat,
  input  logic [CLS_DW-1:0] in_label,
  input  logic              in_set_last,
  output logic              state,
  output logic              smp_en,
  output logic              smp_clr,
  output logic              set_clr,
  output logic [DIM-1:0]    im_value,
  output logic [DIM-1:0]    im_pos,
  output logic [CLS_DW-1:0] label,
  output logic              busy
);

  localparam int LVL_W = $clog2(LVL_NUM);
  localparam int STEP  = DIM / (LVL_NUM - 1);
  localparam int CNT_W = $clog2(FEAT_NUM);
  localparam logic MODE_TRAIN = 1'b0;

  typedef enum logic [1:0] {ST_FEAT, ST_END, ST_CLR, ST_SET} fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [CNT_W-1:0]  feat_cnt_q, feat_cnt_d;
  logic [DIM-1:0]    pos_q, pos_d;
  logic              smp_en_q, smp_en_d;
  logic              smp_clr_q, smp_clr_d;
  logic              set_clr_q, set_clr_d;
  logic [DIM-1:0]    im_value_q, im_value_d;
  logic [DIM-1:0]    im_pos_q, im_pos_d;
  logic [CLS_DW-1:0] label_q, label_d;
  logic              state_q, state_d;
  logic              set_last_q, set_last_d;

  logic [LVL_W-1:0]  lvl;
  logic [31:0]       lvl_thr;
  logic [DIM-1:0]    lvl_mask;
  logic              accept;
  logic              last_feat;

  // Quantise by keeping the top LVL_W bits of the feature.
  assign lvl     = LVL_W'(feat >> (FEAT_W - LVL_W));
  assign lvl_thr = 32'(lvl) * 32'(STEP);

  // Thermometer mask: bit j flips when j lies below the level threshold, so
  // adjacent levels differ in exactly STEP bits.
  for (genvar j = 0; j < DIM; j++) begin : g_lvl
    assign lvl_mask[j] = (32'(j) < lvl_thr);
  end

  assign accept    = in_valid && (fsm_q == ST_FEAT);
  assign last_feat = (feat_cnt_q == CNT_W'(FEAT_NUM - 1));

  always_comb begin
    fsm_d      = fsm_q;
    feat_cnt_d = feat_cnt_q;
    pos_d      = pos_q;
    smp_en_d   = 1'b0;
    smp_clr_d  = 1'b0;
    set_clr_d  = 1'b0;
    im_value_d = im_value_q;
    im_pos_d   = im_pos_q;
    label_d    = label_q;
    state_d    = state_q;
    set_last_d = set_last_q;

    case (fsm_q)
      ST_FEAT: begin
        if (accept) begin
          smp_en_d   = 1'b1;
          im_value_d = LVL_SEED ^ lvl_mask;
          im_pos_d   = pos_q;
          // Sample attributes are frozen at feature 0; later changes on
          // mode/in_label/in_set_last are ignored for this sample.
          if (feat_cnt_q == '0) begin
            label_d    = in_label;
            state_d    = mode;
            set_last_d = in_set_last;
          end
          if (last_feat) begin
            feat_cnt_d = '0;
            pos_d      = POS_SEED;
            fsm_d      = ST_END;
          end else begin
            feat_cnt_d = feat_cnt_q + CNT_W'(1);
            pos_d      = {pos_q[DIM-2:0], pos_q[DIM-1]};
          end
        end
      end
      ST_END: begin
        smp_clr_d = 1'b1;
        fsm_d     = ST_CLR;
      end
      ST_CLR: begin
        // Only training samples can close a set.
        if ((state_q == MODE_TRAIN) && set_last_q) begin
          set_clr_d = 1'b1;
          fsm_d     = ST_SET;
        end else begin
          fsm_d = ST_FEAT;
        end
      end
      ST_SET:  fsm_d = ST_FEAT;
      default: fsm_d = ST_FEAT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= ST_FEAT;
      feat_cnt_q <= '0;
      pos_q      <= POS_SEED;
      smp_en_q   <= 1'b0;
      smp_clr_q  <= 1'b0;
      set_clr_q  <= 1'b0;
      im_value_q <= '0;
      im_pos_q   <= '0;
      label_q    <= '0;
      state_q    <= MODE_TRAIN;
      set_last_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      feat_cnt_q <= feat_cnt_d;
      pos_q      <= pos_d;
      smp_en_q   <= smp_en_d;
      smp_clr_q  <= smp_clr_d;
      set_clr_q  <= set_clr_d;
      im_value_q <= im_value_d;
      im_pos_q   <= im_pos_d;
      label_q    <= label_d;
      state_q    <= state_d;
      set_last_q <= set_last_d;
    end
  end

  assign in_ready = (fsm_q == ST_FEAT);
  assign busy     = (fsm_q != ST_FEAT) || (feat_cnt_q != '0);
  assign state    = state_q;
  assign smp_en   = smp_en_q;
  assign smp_clr  = smp_clr_q;
  assign set_clr  = set_clr_q;
  assign im_value = im_value_q;
  assign im_pos   = im_pos_q;
  assign label    = label_q;

endmodule

// File: tb/tb_hdc_sample_feeder.sv
// Bench for hdc_sample_feeder (DIM=16, FEAT_NUM=4, FEAT_W=4, LVL_NUM=4).
// A timeline model predicts, per clock edge, which beats are accepted and on
// which edges the end strobes fall; a negedge process compares every output.
module tb_hdc_sample_feeder;
  localparam int DIM = 16, FN = 4, FW = 4, LN = 4, CW = 5;
  localparam logic [15:0] LS = 16'h00FF, PS = 16'h0001;

  logic clk = 1'b0, rst_n = 1'b1, mode = 1'b0, in_valid = 1'b0, in_set_last = 1'b0;
  logic [FW-1:0] feat = '0;
  logic [CW-1:0] in_label = '0;
  logic in_ready, state, smp_en, smp_clr, set_clr, busy;
  logic [DIM-1:0] im_value, im_pos;
  logic [CW-1:0] label;

  hdc_sample_feeder #(.DIM(DIM), .FEAT_NUM(FN), .FEAT_W(FW), .LVL_NUM(LN), .CLS_DW(CW),
                      .LVL_SEED(LS), .POS_SEED(PS)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .feat(feat), .in_label(in_label), .in_set_last(in_set_last), .state(state),
    .smp_en(smp_en), .smp_clr(smp_clr), .set_clr(set_clr), .im_value(im_value),
    .im_pos(im_pos), .label(label), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lvl_hv(input int l);
    logic [15:0] v;
    v = LS;
    for (int j = 0; j < DIM; j++) if (j < l * (DIM / (LN - 1))) v[j] = ~v[j];
    return v;
  endfunction

  function automatic logic [15:0] rotl(input logic [15:0] s, input int k);
    logic [15:0] v;
    v = s;
    for (int i = 0; i < k; i++) v = {v[14:0], v[15]};
    return v;
  endfunction

  // ---- timeline model ----
  int ecnt = 0, ready_from = 0, clr_edge = -1, set_edge = -1, m_idx = 0;
  logic m_setlast = 1'b0, exp_en = 1'b0, exp_state = 1'b0;
  logic [15:0] exp_value = '0, exp_pos = '0;
  logic [CW-1:0] exp_label = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idx <= 0; ready_from <= ecnt; clr_edge <= -1; set_edge <= -1;
      exp_en <= 1'b0; exp_value <= '0; exp_pos <= '0; exp_label <= '0;
      exp_state <= 1'b0; m_setlast <= 1'b0;
    end else begin
      ecnt <= ecnt + 1;
      exp_en <= 1'b0;
      if (in_valid && ecnt >= ready_from) begin
        exp_en <= 1'b1;
        exp_value <= lvl_hv(int'(feat) >> (FW - 2));
        exp_pos <= rotl(PS, m_idx % DIM);
        if (m_idx == 0) begin
          exp_label <= in_label; exp_state <= mode; m_setlast <= in_set_last;
        end
        if (m_idx == FN - 1) begin
          m_idx <= 0;
          clr_edge <= ecnt + 2;
          if (!exp_state && m_setlast) begin
            set_edge <= ecnt + 3; ready_from <= ecnt + 4;
          end else begin
            set_edge <= -1; ready_from <= ecnt + 3;
          end
        end else m_idx <= m_idx + 1;
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) if (cmp_en) begin
    logic er;
    er = (ecnt >= ready_from);
    chk("in_ready", in_ready, er);
    chk("busy", busy, !er || m_idx != 0);
    chk("smp_en", smp_en, exp_en);
    chk("smp_clr", smp_clr, rst_n && ecnt == clr_edge);
    chk("set_clr", set_clr, rst_n && ecnt == set_edge);
    chk("im_value", im_value, exp_value);
    chk("im_pos", im_pos, exp_pos);
    chk("label", label, exp_label);
    chk("state", state, exp_state);
    chk("strobe_excl", (32'(smp_en) + 32'(smp_clr) + 32'(set_clr)) <= 1, 1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [FW-1:0] f, input int idle);
    int to;
    bit took;
    in_valid = 1'b0;
    repeat (idle) tick();
    in_valid = 1'b1; feat = f; took = 1'b0; to = 0;
    while (!took && to < 30) begin
      @(negedge clk); took = in_ready;
      tick(); to++;
    end
    in_valid = 1'b0;
    if (!took) begin
      checks++; failures++;
      $display("FAIL beat_timeout: got no accept expected accept at %0t", $time);
    end
  endtask

  logic [FW-1:0] fv [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
  logic [15:0]   ev [4] = '{16'h00FF, 16'h00E0, 16'h0300, 16'h7F00};
  logic [15:0]   pv [4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};

  initial begin
    // model pins
    chk("pin_lvl0", lvl_hv(0), 16'h00FF);
    chk("pin_lvl3", lvl_hv(3), 16'h7F00);
    chk("pin_rot3", rotl(PS, 3), 16'h0008);

    // 1. reset then idle
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick(); tick();
    chk("t1_ready", in_ready, 1); chk("t1_smp_en", smp_en, 0);
    chk("t1_label", label, 0); chk("t1_busy", busy, 0);

    // 2. train sample, no set end
    mode = 1'b0; in_label = 5'd3; in_set_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(fv[i], 0);
      chk("t2_val", im_value, ev[i]); chk("t2_pos", im_pos, pv[i]); chk("t2_en", smp_en, 1);
    end
    chk("t2_label", label, 3); chk("t2_ready_end", in_ready, 0);
    tick(); chk("t2_clr", smp_clr, 1); chk("t2_en_off", smp_en, 0);
    tick(); chk("t2_noset", set_clr, 0); chk("t2_ready", in_ready, 1);

    // 3. train sample closing the set
    in_set_last = 1'b1;
    for (int i = 0; i < 4; i++) beat(fv[i], 0);
    chk("t3_ready0", in_ready, 0);
    tick(); chk("t3_clr", smp_clr, 1); chk("t3_ready1", in_ready, 0);
    tick(); chk("t3_set", set_clr, 1); chk("t3_ready2", in_ready, 0);
    tick(); chk("t3_set_off", set_clr, 0); chk("t3_ready3", in_ready, 1);

    // 4. predict sample, mode toggled mid-sample
    mode = 1'b1; in_label = 5'd7; in_set_last = 1'b1;
    beat(4'd1, 0); beat(4'd2, 0);
    mode = 1'b0;
    beat(4'd3, 0); beat(4'd4, 0);
    chk("t4_state", state, 1);
    tick(); chk("t4_clr", smp_clr, 1);
    tick(); chk("t4_noset", set_clr, 0); chk("t4_ready", in_ready, 1);

    // 5. gapped valid
    mode = 1'b0; in_set_last = 1'b0; in_label = 5'd1;
    for (int i = 0; i < 4; i++) begin
      beat(fv[i], 2); chk("t5_pos", im_pos, pv[i]);
    end
    beat(4'd9, 0); chk("t5_restart_pos", im_pos, 16'h0001);
    for (int i = 1; i < 4; i++) beat(4'd9, 0);
    repeat (3) tick();

    // 6. reset mid-sample
    in_label = 5'd9;
    beat(4'd6, 0); beat(4'd7, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_en", smp_en, 0); chk("t6_pos", im_pos, 0); chk("t6_val", im_value, 0);
    chk("t6_label", label, 0); chk("t6_busy", busy, 0); chk("t6_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    in_label = 5'd12;
    beat(4'd8, 0); chk("t6_first_pos", im_pos, 16'h0001); chk("t6_relabel", label, 12);
    for (int i = 1; i < 4; i++) beat(4'd8, 0);
    repeat (4) tick();

    // randomized samples; sample attributes also churn mid-sample
    for (int s = 0; s < 40; s++) begin
      mode = 1'($urandom); in_label = CW'($urandom); in_set_last = 1'($urandom);
      for (int b = 0; b < FN; b++) begin
        beat(FW'($urandom_range(0, 15)), $urandom_range(0, 2));
        mode = 1'($urandom); in_label = CW'($urandom); in_set_last = 1'($urandom);
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) tick();
    end
    repeat (6) tick();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
